// File: rtl/decode_stage_if.sv
// Bundles the fetch, hazard and write-back inputs and the decoded outputs of the decode stage.
// master drives the stage inputs; slave is the decode stage itself.
interface decode_stage_if #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int CNT_W   = 16
);
  localparam int ADDR_W = $clog2(REG_CNT);

  logic              ihit;
  logic              flush;
  logic [31:0]       instr_in;
  logic [31:0]       npc_in;
  logic              ex_memread;
  logic [ADDR_W-1:0] ex_dest;
  logic              wen;
  logic [ADDR_W-1:0] wsel;
  logic [DATA_W-1:0] wdat;

  logic              stall;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [31:0]       id_npc;
  logic [DATA_W-1:0] rdat1;
  logic [DATA_W-1:0] rdat2;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] lui_val;
  logic [4:0]        shamt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output ihit, flush, instr_in, npc_in, ex_memread, ex_dest, wen, wsel, wdat,
    input  stall, id_valid, id_instr, id_npc, rdat1, rdat2,
           imm_sext, imm_zext, lui_val, shamt, stall_cnt
  );

  modport slave (
    input  ihit, flush, instr_in, npc_in, ex_memread, ex_dest, wen, wsel, wdat,
    output stall, id_valid, id_instr, id_npc, rdat1, rdat2,
           imm_sext, imm_zext, lui_val, shamt, stall_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS decode stage: IF/ID latch, register file with write-port bypass,
// load-use hazard detection and a saturating stall counter.
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int CNT_W   = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  decode_stage_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_CNT);

  logic              id_valid_q, id_valid_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [31:0]       id_npc_q, id_npc_d;
  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [ADDR_W-1:0] rs_idx;
  logic [ADDR_W-1:0] rt_idx;
  logic              wr_en;
  logic              stall;

  assign rs_idx = ADDR_W'(id_instr_q[25:21]);
  assign rt_idx = ADDR_W'(id_instr_q[20:16]);
  assign wr_en  = bus.wen && (bus.wsel != '0);

  // rt is compared even for I-type consumers, so this can stall needlessly but never misses a hazard.
  assign stall = id_valid_q && bus.ex_memread && (bus.ex_dest != '0) &&
                 ((bus.ex_dest == rs_idx) || (bus.ex_dest == rt_idx));

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_npc_d   = id_npc_q;
    if (bus.flush) begin
      id_valid_d = 1'b0;
      id_instr_d = '0;
      id_npc_d   = '0;
    end else if (stall) begin
      id_valid_d = id_valid_q;
    end else if (bus.ihit) begin
      id_valid_d = 1'b1;
      id_instr_d = bus.instr_in;
      id_npc_d   = bus.npc_in;
    end else begin
      id_valid_d = 1'b0;
      id_instr_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < REG_CNT; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[bus.wsel] = bus.wdat;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !bus.flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      id_valid_q  <= 1'b0;
      id_instr_q  <= '0;
      id_npc_q    <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_npc_q    <= id_npc_d;
      stall_cnt_q <= stall_cnt_d;
      regs_q      <= regs_d;
    end
  end

  // Register 0 is never written, so reading the array at index 0 already yields zero.
  always_comb begin
    bus.rdat1 = (wr_en && (bus.wsel == rs_idx)) ? bus.wdat : regs_q[rs_idx];
    bus.rdat2 = (wr_en && (bus.wsel == rt_idx)) ? bus.wdat : regs_q[rt_idx];
  end

  assign bus.stall     = stall;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_npc    = id_npc_q;
  assign bus.imm_sext  = DATA_W'($signed(id_instr_q[15:0]));
  assign bus.imm_zext  = DATA_W'(id_instr_q[15:0]);
  assign bus.lui_val   = DATA_W'({id_instr_q[15:0], 16'h0000});
  assign bus.shamt     = id_instr_q[10:6];
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for the single-cycle behaviour,
// then hand sequences for counter saturation, asynchronous reset mid-stall and immediate decode.
module tb_decode_stage;
  localparam int DATA_W  = 32;
  localparam int REG_CNT = 32;
  localparam int CNT_W   = 4;
  localparam int NVEC    = 15;

  logic CLK;
  logic nRST;
  int   compared;
  int   mismatched;

  decode_stage_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .CNT_W(CNT_W)) bus ();

  decode_stage #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ihit;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        memread;
    logic [4:0]  dest;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic [31:0] e_rdat1;
    logic [31:0] e_rdat2;
    logic [31:0] e_sext;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic ih, input logic fl, input logic [31:0] ins, input logic [31:0] np,
    input logic mr, input logic [4:0] ds, input logic we, input logic [4:0] ws,
    input logic [31:0] wd, input logic s, input logic v, input logic [31:0] ei,
    input logic [31:0] en, input logic [31:0] r1, input logic [31:0] r2,
    input logic [31:0] sx, input logic [3:0] c);
    vec_t r;
    r.ihit = ih; r.flush = fl; r.instr = ins; r.npc = np;
    r.memread = mr; r.dest = ds; r.wen = we; r.wsel = ws; r.wdat = wd;
    r.e_stall = s; r.e_valid = v; r.e_instr = ei; r.e_npc = en;
    r.e_rdat1 = r1; r.e_rdat2 = r2; r.e_sext = sx; r.e_cnt = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a record's inputs just after the falling edge and let combinational outputs settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    bus.ihit       = v.ihit;
    bus.flush      = v.flush;
    bus.instr_in   = v.instr;
    bus.npc_in     = v.npc;
    bus.ex_memread = v.memread;
    bus.ex_dest    = v.dest;
    bus.wen        = v.wen;
    bus.wsel       = v.wsel;
    bus.wdat       = v.wdat;
    #2;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("v%0d.stall", idx),     32'(bus.stall),     32'(v.e_stall));
    check($sformatf("v%0d.id_valid", idx),  32'(bus.id_valid),  32'(v.e_valid));
    check($sformatf("v%0d.id_instr", idx),  bus.id_instr,       v.e_instr);
    check($sformatf("v%0d.id_npc", idx),    bus.id_npc,         v.e_npc);
    check($sformatf("v%0d.rdat1", idx),     bus.rdat1,          v.e_rdat1);
    check($sformatf("v%0d.rdat2", idx),     bus.rdat2,          v.e_rdat2);
    check($sformatf("v%0d.imm_sext", idx),  bus.imm_sext,       v.e_sext);
    check($sformatf("v%0d.stall_cnt", idx), 32'(bus.stall_cnt), 32'(v.e_cnt));
  endtask

  task automatic driveIdle();
    bus.ihit = 1'b0; bus.flush = 1'b0; bus.instr_in = '0; bus.npc_in = '0;
    bus.ex_memread = 1'b0; bus.ex_dest = '0; bus.wen = 1'b0; bus.wsel = '0; bus.wdat = '0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    nRST = 1'b0;
    driveIdle();

    // add $5,$3,$6 = 0x00662820 (rs=3, rt=6); lw $4,8($3) = 0x8C640008 (rs=3, rt=4)
    vecs[0]  = mk(0,0,32'h0,32'h0,       0,0, 0,0,32'h0,    0,0,32'h0,32'h0,  32'h0,32'h0,32'h0,0);
    vecs[1]  = mk(0,0,32'h0,32'h0,       0,0, 1,1,32'h5,    0,0,32'h0,32'h0,  32'h0,32'h0,32'h0,0);
    vecs[2]  = mk(0,0,32'h0,32'h0,       0,0, 1,3,32'h33,   0,0,32'h0,32'h0,  32'h0,32'h0,32'h0,0);
    vecs[3]  = mk(1,0,32'h2022FFFC,32'h4,0,0, 0,0,32'h0,    0,0,32'h0,32'h0,  32'h0,32'h0,32'h0,0);
    vecs[4]  = mk(1,0,32'h2022FFFC,32'h4,0,0, 1,1,32'h1234, 0,1,32'h2022FFFC,32'h4, 32'h1234,32'h0,32'hFFFFFFFC,0);
    vecs[5]  = mk(0,0,32'h0,32'h0,       0,0, 1,0,32'hFFFF, 0,1,32'h2022FFFC,32'h4, 32'h1234,32'h0,32'hFFFFFFFC,0);
    vecs[6]  = mk(0,0,32'h0,32'h0,       0,0, 1,0,32'hFFFF, 0,0,32'h0,32'h4,  32'h0,32'h0,32'h0,0);
    vecs[7]  = mk(1,0,32'h00662820,32'h10,0,0,0,0,32'h0,    0,0,32'h0,32'h4,  32'h0,32'h0,32'h0,0);
    vecs[8]  = mk(1,0,32'h8C640008,32'h14,1,3,0,0,32'h0,    1,1,32'h00662820,32'h10, 32'h33,32'h0,32'h2820,0);
    vecs[9]  = mk(1,0,32'h8C640008,32'h14,1,3,0,0,32'h0,    1,1,32'h00662820,32'h10, 32'h33,32'h0,32'h2820,1);
    vecs[10] = mk(1,0,32'h8C640008,32'h14,0,3,1,6,32'h66,   0,1,32'h00662820,32'h10, 32'h33,32'h66,32'h2820,2);
    vecs[11] = mk(0,0,32'h0,32'h0,       1,0, 0,0,32'h0,    0,1,32'h8C640008,32'h14, 32'h33,32'h0,32'h8,2);
    vecs[12] = mk(1,0,32'h00662820,32'h18,0,0,0,0,32'h0,    0,0,32'h0,32'h14, 32'h0,32'h0,32'h0,2);
    vecs[13] = mk(1,1,32'h8C640008,32'h1C,1,6,0,0,32'h0,    1,1,32'h00662820,32'h18, 32'h33,32'h66,32'h2820,2);
    vecs[14] = mk(0,0,32'h0,32'h0,       1,6, 0,0,32'h0,    0,0,32'h0,32'h0,  32'h0,32'h0,32'h0,2);

    $display("[TB] reset for two cycles");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2;
    check("reset.id_valid",  32'(bus.id_valid),  32'h0);
    check("reset.id_instr",  bus.id_instr,       32'h0);
    check("reset.id_npc",    bus.id_npc,         32'h0);
    check("reset.stall",     32'(bus.stall),     32'h0);
    check("reset.stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check("reset.lui_val",   bus.lui_val,        32'h0);
    nRST = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    $display("[TB] stall counter saturation");
    @(negedge CLK);
    driveIdle();
    bus.ihit = 1'b1; bus.instr_in = 32'h00662820; bus.npc_in = 32'h20;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      driveIdle();
      bus.ex_memread = 1'b1; bus.ex_dest = 5'd3;
      #2;
      check($sformatf("sat%0d.stall", i), 32'(bus.stall), 32'h1);
      check($sformatf("sat%0d.stall_cnt", i), 32'(bus.stall_cnt), (2 + i > 15) ? 32'd15 : 32'(2 + i));
    end
    @(negedge CLK);
    #2;
    check("sat.final_cnt",  32'(bus.stall_cnt), 32'd15);
    check("sat.held_instr", bus.id_instr,       32'h00662820);

    $display("[TB] asynchronous reset during a stall");
    nRST = 1'b0;
    #1;
    check("areset.id_valid",  32'(bus.id_valid),  32'h0);
    check("areset.id_instr",  bus.id_instr,       32'h0);
    check("areset.stall",     32'(bus.stall),     32'h0);
    check("areset.stall_cnt", 32'(bus.stall_cnt), 32'h0);
    @(negedge CLK);
    driveIdle();
    nRST = 1'b1;

    $display("[TB] immediate decode after reset");
    @(negedge CLK);
    bus.ihit = 1'b1; bus.instr_in = 32'h2022FFFC; bus.npc_in = 32'h4;
    @(negedge CLK);
    driveIdle();
    #2;
    check("imm.id_valid", 32'(bus.id_valid), 32'h1);
    check("imm.id_npc",   bus.id_npc,        32'h4);
    check("imm.sext",     bus.imm_sext,      32'hFFFFFFFC);
    check("imm.zext",     bus.imm_zext,      32'h0000FFFC);
    check("imm.lui",      bus.lui_val,       32'hFFFC0000);
    check("imm.shamt",    32'(bus.shamt),    32'd31);
    check("imm.rdat1",    bus.rdat1,         32'h0);
    check("imm.rdat2",    bus.rdat2,         32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised decode stage for the 5-stage pipelined MIPS core: holds the IF/ID pipeline latch, the register file with a same-cycle write-back bypass, and load-use hazard detection. It produces the stall and decoded-operand signals consumed by the ID/EX latch and the PC logic. It generalises the earlier decode/write-back stage with configurable data width and register count, stall handling, write-port forwarding and a stall performance counter.

## Interface
- DATA_W, 32, register/operand width (≥ 32)
- REG_CNT, 32, number of architectural registers (power of two, ≥ 2); ADDR_W = log2(REG_CNT)
- CNT_W, 16, width of the stall performance counter
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  fetch delivers a valid instruction this cycle
- flush  in  1  squash the IF/ID latch (taken branch/jump)
- instr_in  in  32  fetched instruction
- npc_in  in  32  PC+4 of the fetched instruction
- ex_memread  in  1  instruction in EX is a load
- ex_dest  in  ADDR_W  destination register of the EX instruction
- wen  in  1  write-back enable
- wsel  in  ADDR_W  write-back register index
- wdat  in  DATA_W  write-back data
- stall  out  1  load-use hazard: hold PC and IF/ID, insert bubble into ID/EX
- id_valid  out  1  latch holds a live instruction
- id_instr  out  32  latched instruction
- id_npc  out  32  latched PC+4
- rdat1, rdat2  out  DATA_W  operands for rs (instr[25:21]) and rt (instr[20:16]), low ADDR_W bits used as index
- imm_sext, imm_zext  out  DATA_W  sign-/zero-extended instr[15:0]
- lui_val  out  DATA_W  {instr[15:0], 16'b0} zero-extended to DATA_W
- shamt  out  5  instr[10:6]
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- IF/ID latch update, priority highest first at each rising edge:
  - flush: id_valid←0, id_instr←0 (nop), id_npc←0.
  - stall: hold all latch contents.
  - ihit: id_valid←1, id_instr←instr_in, id_npc←npc_in.
  - otherwise: bubble, with id_valid←0 and id_instr←0; id_npc holds its value.
- Hazard: stall = id_valid & ex_memread & (ex_dest≠0) & (ex_dest==rs | ex_dest==rt). The comparison is purely combinational on the latch contents. rt is always compared, so the check is conservative.
- Register file: REG_CNT×DATA_W. Register 0 reads 0 and writes to it are ignored. All registers clear on reset. A write occurs at the rising edge when wen=1.
- Bypass: when wen=1, wsel≠0 and wsel==rs, rdat1=wdat in the same cycle. rdat2 uses the same rule with rt. Otherwise operands are the stored values.
- Immediate and shift outputs are combinational from id_instr.
- stall_cnt increments at each edge where stall=1 and flush=0. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset (asynchronous, nRST=0): id_valid=0, id_instr=0, id_npc=0, all registers=0, stall_cnt=0. As a consequence, stall=0, rdat1=rdat2=0 and all immediates are 0.
- Latency: instr_in captured at edge N appears on id_instr/rdat* after edge N, i.e. one cycle.
- Reads are combinational from id_instr and the register array, with a same-cycle bypass from the write port.
- A load-use stall holds the latch for one cycle per asserted stall. Once the load leaves EX, ex_memread drops and stall deasserts combinationally.
- flush together with stall: flush wins. The latch clears, stall_cnt does not increment, and stall deasserts the next cycle because id_valid=0.
- flush together with ihit: flush wins and the fetched instruction is discarded.
- Reset asserted mid-stall clears the latch and counter immediately, without waiting for a clock edge.

## Test plan
- Reset then idle: nRST low for 2 cycles, then high with ihit=0 -> all outputs 0, stall=0, stall_cnt=0.
- Fetch and decode: ihit=1, instr_in=0x2022FFFC (addi $2,$1,-4), npc_in=0x4 -> next cycle id_valid=1, imm_sext=0xFFFFFFFC, imm_zext=0x0000FFFC, lui_val=0xFFFC0000, id_npc=0x4.
- Write-back bypass: $1 holds 5; in the same cycle, wen=1, wsel=1, wdat=0x1234 while id_instr reads rs=1 -> rdat1=0x1234 that cycle, and $1=0x1234 thereafter. Writing wsel=0 with wdat=0xFFFF leaves rdat reading 0.
- Load-use stall: id_instr with rs=3, ex_memread=1, ex_dest=3, ihit=1 with a new instr_in -> stall=1, latch holds, stall_cnt increments by 1. With ex_dest=0 or ex_memread=0 -> stall=0.
- Flush priority: stall condition active plus flush=1 -> next cycle id_valid=0, id_instr=0, stall_cnt unchanged.
- Counter saturation: with CNT_W=4, hold the stall condition for 20 cycles -> stall_cnt stops at 15.
